imm_gen_stage: RTL
==================

# imm_gen_stage

Registered, parametrised RISC-V immediate-generation stage with valid/ready handshakes on both sides. It sits between fetch and decode/execute, accepts one 32-bit instruction per cycle, and returns the sign-extended immediate together with a format code, an unknown-opcode flag and a passthrough tag. It supports XLEN = 32 or 64 and absorbs back-pressure through a 2-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`.

## Interface
- `XLEN`, default 32: immediate width; legal values are 32 and 64.
- `TAG_W`, default 32: width of the sideband tag (typically the PC), carried unchanged.
- `clk  in  1`: the single clock; all state updates on the rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `in_valid  in  1`: upstream has an instruction.
- `in_ready  out  1`: stage can accept; a transfer occurs when `in_valid && in_ready`.
- `in_instr  in  32`: raw instruction.
- `in_tag  in  TAG_W`: sideband tag.
- `out_valid  out  1`: head entry is valid.
- `out_ready  in  1`: downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `out_imm  out  XLEN`: sign-extended immediate.
- `out_fmt  out  3`: 0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J; codes 6 and 7 are never driven.
- `out_unknown  out  1`: opcode is not in the RV32I base set.
- `out_tag  out  TAG_W`: tag of the head entry.

## Operation
- Opcode is `instr[6:0]`. Format and immediate are computed combinationally at the input and stored with the entry. Outputs are driven from storage only.
- Opcode-to-format mapping:
  - I: 0010011, 0000011, 1100111, 0001111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - NONE with `out_unknown`=0: 0110011.
  - NONE with `out_unknown`=1: any other opcode.
- Immediate bit fields (before extension):
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - NONE: all-zero immediate.
- Every format, including U, is sign-extended from `instr[31]` to XLEN. For XLEN=32 the U result is exactly `{instr[31:12], 12'b0}`.
- Storage is a 2-entry FIFO (head register plus skid register). States are EMPTY, ONE and FULL.
  - EMPTY: on accept, go to ONE.
  - ONE:
    - accept without pop: go to FULL.
    - pop without accept: go to EMPTY.
    - accept and pop together: stay in ONE; the new entry replaces the head.
  - FULL: pop moves the skid entry to the head and goes to ONE. No accept is possible in FULL.
- `in_ready` = (state != FULL) && !rst. `out_valid` = (state != EMPTY).
- Strict FIFO order. No entry is dropped or duplicated.
- While an entry is the head and `out_ready`=0, `out_imm`, `out_fmt`, `out_unknown` and `out_tag` hold stable.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible at the outputs after edge N, when the stage was EMPTY, or ONE with a simultaneous pop.
- Throughput is 1 instruction per cycle while `out_ready`=1.
- `in_ready` is a function of registered state and `rst` only. It has no combinational path from `out_ready`, `in_valid` or `in_instr`.
- Reset behaviour:
  - While `rst`=1: `in_ready`=0 and no input transfer occurs.
  - At the first edge with `rst`=1: state becomes EMPTY and `out_valid`=0.
  - Stored entries are discarded, including mid-stream with the stage FULL.
  - Data outputs reset to `out_imm`=0, `out_fmt`=0, `out_unknown`=0, `out_tag`=0.
  - The cycle after `rst` deasserts: `in_ready`=1.
- Handshake rules:
  - `out_valid` never deasserts without a pop.
  - Accepting in the same cycle as a pop is legal in ONE and EMPTY.
  - In FULL, only a pop can occur.

## Test plan
- I-format: XLEN=32, `in_instr`=0xFFF00093 (addi x1,x0,-1) with `out_ready`=1 → one cycle later `out_imm`=0xFFFFFFFF, `out_fmt`=1, `out_unknown`=0.
- S, J and U formats, one per cycle:
  - 0xFE112E23 (sw x1,-4(x2)) → `out_imm`=0xFFFFFFFC, `out_fmt`=2.
  - 0xFFDFF06F (jal x0,-4) → `out_imm`=0xFFFFFFFC, `out_fmt`=5.
  - 0x800000B7 (lui) → `out_imm`=0x80000000, `out_fmt`=4.
- XLEN=64: 0x800000B7 → `out_imm`=0xFFFFFFFF80000000; 0x0010000B (custom-0) → `out_imm`=0, `out_fmt`=0, `out_unknown`=1.
- Back-pressure: hold `out_ready`=0 and stream tags 1, 2, 3 → `in_ready` drops after tag 2 is accepted and tag 3 is held upstream. Then release `out_ready` → outputs appear in order 1, 2, 3 with no gap once streaming, and the head stays stable while stalled.
- Simultaneous accept and pop in ONE for 10 consecutive cycles → one output per cycle, state remains ONE, and `in_ready` stays 1 throughout.
- Reset mid-operation: FULL, then `rst`=1 for one cycle → next cycle `out_valid`=0 and both entries are lost. `in_ready`=0 during reset and 1 afterwards. The first post-reset instruction emerges with 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RISC-V immediate generator with 2-entry skid buffer
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_unknown,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    logic [1:0]       state;
    logic [2:0]       fmt;
    logic             unknown;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm;
    logic             acc;
    logic             pop;
    logic [XLEN-1:0]  head_imm, skid_imm;
    logic [2:0]       head_fmt, skid_fmt;
    logic             head_unk, skid_unk;
    logic [TAG_W-1:0] head_tag, skid_tag;

    // decode opcode into format code and unknown flag
    always_comb begin
        fmt     = 3'd0;
        unknown = 1'b0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: fmt = 3'd1;
            7'b0100011: fmt = 3'd2;
            7'b1100011: fmt = 3'd3;
            7'b0110111, 7'b0010111: fmt = 3'd4;
            7'b1101111: fmt = 3'd5;
            7'b0110011: fmt = 3'd0;
            default: unknown = 1'b1;
        endcase
    end

    // assemble the 32-bit sign-extended immediate for the decoded format
    always_comb begin
        imm32 = fmt == 3'd1 ? {{20{in_instr[31]}}, in_instr[31:20]} :
                fmt == 3'd2 ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                fmt == 3'd3 ? {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                fmt == 3'd4 ? {in_instr[31:12], 12'b0} :
                fmt == 3'd5 ? {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
                32'd0;
    end

    assign imm         = XLEN'($signed(imm32));
    assign in_ready    = (state != FULL) && !rst;
    assign out_valid   = (state != EMPTY);
    assign acc         = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign out_imm     = head_imm;
    assign out_fmt     = head_fmt;
    assign out_unknown = head_unk;
    assign out_tag     = head_tag;

    // head/skid storage and occupancy state; new data goes to head when it is free or being popped
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            head_imm <= '0;
            head_fmt <= '0;
            head_unk <= 1'b0;
            head_tag <= '0;
            skid_imm <= '0;
            skid_fmt <= '0;
            skid_unk <= 1'b0;
            skid_tag <= '0;
        end else begin
            if (acc && (state == EMPTY || pop)) begin
                head_imm <= imm;
                head_fmt <= fmt;
                head_unk <= unknown;
                head_tag <= in_tag;
            end else if (pop && state == FULL) begin
                head_imm <= skid_imm;
                head_fmt <= skid_fmt;
                head_unk <= skid_unk;
                head_tag <= skid_tag;
            end
            if (acc && state == ONE && !pop) begin
                skid_imm <= imm;
                skid_fmt <= fmt;
                skid_unk <= unknown;
                skid_tag <= in_tag;
            end
            state <= (acc && !pop) ? (state == EMPTY ? ONE : FULL) :
                     (!acc && pop) ? (state == FULL ? ONE : EMPTY) : state;
        end
    end
endmodule
